// File: rtl/bit_index_pkg.sv
// Shared types and helpers for the bit-index packer: FSM state and width/range utilities.
package bit_index_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Width of an index/counter able to hold values 0..n-1, never narrower than 1 bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic idx_in_range(input int unsigned idx, input int unsigned width);
        return idx < width;
    endfunction

endpackage

// File: rtl/idx_onehot_dec.sv
// Combinational index to one-hot decoder; in_range flags indices that land inside the mask.
// Zero latency; no flow control. Out-of-range indices decode to an all-zero vector.
module idx_onehot_dec
    import bit_index_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(DATA_W)
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] onehot,
    output logic              in_range
);

    always_comb begin
        onehot   = '0;
        in_range = idx_in_range(32'(idx), 32'(DATA_W));
        for (int i = 0; i < DATA_W; i++) begin
            if (idx == IDX_W'(i)) onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/bit_index_packer.sv
// Rebuilds a DATA_W-bit mask from a framed stream of bit indices; optional set-bit count with BIT_INDEX_PACKER_CNT_EN.
// Latency: mask valid 1 cycle after the last beat is accepted.
// Backpressure: in_ready drops while a completed mask waits in HOLD for out_ready; no same-cycle bypass.
module bit_index_packer
    import bit_index_pkg::*;
#(
    parameter  int DATA_W = 64,
    localparam int IDX_W  = $clog2(DATA_W),
    localparam int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_null,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mask,
    output logic              out_dup,
`ifdef BIT_INDEX_PACKER_CNT_EN
    output logic              out_oor,
    output logic [CNT_W-1:0]  out_cnt
`else
    output logic              out_oor
`endif
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mask_nxt;
    logic              dup_nxt, oor_nxt;
    logic [DATA_W-1:0] dec_onehot;
    logic              dec_in_range;
    logic              accept;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;

    idx_onehot_dec #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_dec (
        .idx      (in_idx),
        .onehot   (dec_onehot),
        .in_range (dec_in_range)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        mask_nxt  = out_mask;
        dup_nxt   = out_dup;
        oor_nxt   = out_oor;
        cnt_nxt   = cnt_q;
        case (state)
            ACCUM: begin
                if (accept && !in_null) begin
                    if (dec_in_range) begin
                        mask_nxt = out_mask | dec_onehot;
                        if ((out_mask & dec_onehot) != '0) dup_nxt = 1'b1;
                        else                               cnt_nxt = cnt_q + CNT_W'(1);
                    end else begin
                        oor_nxt = 1'b1;
                    end
                end
                if (accept && in_last) state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACCUM;
                    mask_nxt  = '0;
                    dup_nxt   = 1'b0;
                    oor_nxt   = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                // Corrupted state register: drop the frame and restart accumulation.
                state_nxt = ACCUM;
                mask_nxt  = '0;
                dup_nxt   = 1'b0;
                oor_nxt   = 1'b0;
                cnt_nxt   = '0;
`ifndef SYNTHESIS
                $error("bit_index_packer: illegal state");
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ACCUM;
            out_mask <= '0;
            out_dup  <= 1'b0;
            out_oor  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            out_mask <= mask_nxt;
            out_dup  <= dup_nxt;
            out_oor  <= oor_nxt;
            cnt_q    <= cnt_nxt;
        end
    end

`ifdef BIT_INDEX_PACKER_CNT_EN
    assign out_cnt = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_bit_index_packer.sv
// Directed self-checking bench for bit_index_packer (64-bit instance plus a 48-bit instance for out-of-range indices).
module tb_bit_index_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_null, in_last, out_ready;
    logic [5:0]  in_idx;
    logic        in_ready, out_valid, out_dup, out_oor;
    logic [63:0] out_mask;
    logic [6:0]  out_cnt;

    logic        v48, null48, last48, ordy48;
    logic [5:0]  idx48;
    logic        irdy48, ovld48, dup48, oor48;
    logic [47:0] mask48;
    logic [5:0]  cnt48;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_index_packer #(.DATA_W(64)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_null   (in_null),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_dup   (out_dup),
`ifdef BIT_INDEX_PACKER_CNT_EN
        .out_oor   (out_oor),
        .out_cnt   (out_cnt)
`else
        .out_oor   (out_oor)
`endif
    );

    bit_index_packer #(.DATA_W(48)) u_dut48 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (v48),
        .in_ready  (irdy48),
        .in_idx    (idx48),
        .in_null   (null48),
        .in_last   (last48),
        .out_valid (ovld48),
        .out_ready (ordy48),
        .out_mask  (mask48),
        .out_dup   (dup48),
`ifdef BIT_INDEX_PACKER_CNT_EN
        .out_oor   (oor48),
        .out_cnt   (cnt48)
`else
        .out_oor   (oor48)
`endif
    );

`ifndef BIT_INDEX_PACKER_CNT_EN
    assign out_cnt = '0;
    assign cnt48   = '0;
`endif

    task automatic beat(input int idx, input bit nul, input bit last);
        in_valid = 1'b1; in_idx = 6'(idx); in_null = nul; in_last = last;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL beat_in_ready idx=%0d got=%b exp=1", idx, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_null = 1'b0; in_last = 1'b0;
    endtask

    task automatic beat48(input int idx, input bit last);
        v48 = 1'b1; idx48 = 6'(idx); null48 = 1'b0; last48 = last;
        @(posedge clk); #1;
        v48 = 1'b0; last48 = 1'b0;
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++;
        if (out_valid !== 1'b0 || out_mask !== 64'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_async valid=%b mask=%h rdy=%b exp 0/0/1", out_valid, out_mask, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (out_dup !== 1'b0 || out_oor !== 1'b0 || out_cnt !== 7'd0) begin
            bad++; $display("FAIL reset_flags dup=%b oor=%b cnt=%0d exp 0", out_dup, out_oor, out_cnt);
        end
        total++;
        if (ovld48 !== 1'b0 || mask48 !== 48'h0 || irdy48 !== 1'b1) begin
            bad++; $display("FAIL reset_48 valid=%b mask=%h rdy=%b exp 0/0/1", ovld48, mask48, irdy48);
        end
    endtask

    task automatic test_back_to_back();
        beat(3, 0, 0); beat(10, 0, 0); beat(63, 0, 1);
        total++;
        if (out_valid !== 1'b1 || out_mask !== 64'h8000_0000_0000_0408) begin
            bad++; $display("FAIL b2b_mask valid=%b got=%h exp=8000000000000408", out_valid, out_mask);
        end
        total++;
        if (out_dup !== 1'b0 || out_oor !== 1'b0) begin
            bad++; $display("FAIL b2b_flags dup=%b oor=%b exp 0/0", out_dup, out_oor);
        end
`ifdef BIT_INDEX_PACKER_CNT_EN
        total++;
        if (out_cnt !== 7'd3) begin bad++; $display("FAIL b2b_cnt got=%0d exp=3", out_cnt); end
`endif
        release_frame();
    endtask

    task automatic test_null_frame();
        beat(0, 1, 1);
        total++;
        if (out_valid !== 1'b1 || out_mask !== 64'h0 || out_dup !== 1'b0 || out_oor !== 1'b0) begin
            bad++; $display("FAIL null_frame valid=%b mask=%h dup=%b oor=%b exp 1/0/0/0", out_valid, out_mask, out_dup, out_oor);
        end
`ifdef BIT_INDEX_PACKER_CNT_EN
        total++;
        if (out_cnt !== 7'd0) begin bad++; $display("FAIL null_cnt got=%0d exp=0", out_cnt); end
`endif
        release_frame();
    endtask

    task automatic test_dup();
        beat(5, 0, 0); beat(5, 0, 1);
        total++;
        if (out_valid !== 1'b1 || out_mask !== 64'h20) begin
            bad++; $display("FAIL dup_mask valid=%b got=%h exp=20", out_valid, out_mask);
        end
        total++;
        if (out_dup !== 1'b1 || out_oor !== 1'b0) begin
            bad++; $display("FAIL dup_flag dup=%b oor=%b exp 1/0", out_dup, out_oor);
        end
`ifdef BIT_INDEX_PACKER_CNT_EN
        total++;
        if (out_cnt !== 7'd1) begin bad++; $display("FAIL dup_cnt got=%0d exp=1", out_cnt); end
`endif
        release_frame();
        total++;
        if (out_dup !== 1'b0) begin bad++; $display("FAIL dup_clear got=%b exp=0", out_dup); end
    endtask

    task automatic test_hold();
        beat(7, 0, 1);
        in_valid = 1'b1; in_idx = 6'd9; in_last = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (out_valid !== 1'b1 || out_mask !== 64'h80 || in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_c%0d valid=%b mask=%h rdy=%b exp 1/80/0", c, out_valid, out_mask, in_ready);
            end
            @(posedge clk); #1;
        end
        total++;
        if (out_mask !== 64'h80) begin bad++; $display("FAIL hold_no_bit9 got=%h exp=80", out_mask); end
        in_valid = 1'b0; in_last = 1'b0;
        release_frame();
        total++;
        if (out_valid !== 1'b0 || out_mask !== 64'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release valid=%b mask=%h rdy=%b exp 0/0/1", out_valid, out_mask, in_ready);
        end
    endtask

    task automatic test_mid_reset();
        beat(1, 0, 0); beat(2, 0, 0);
        total++;
        if (out_mask !== 64'h6) begin bad++; $display("FAIL partial_mask got=%h exp=6", out_mask); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (out_valid !== 1'b0 || out_mask !== 64'h0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset valid=%b mask=%h rdy=%b exp 0/0/1", out_valid, out_mask, in_ready);
        end
        beat(0, 0, 1);
        total++;
        if (out_valid !== 1'b1 || out_mask !== 64'h1) begin
            bad++; $display("FAIL post_reset_frame valid=%b got=%h exp=1", out_valid, out_mask);
        end
        release_frame();
    endtask

    task automatic test_oor48();
        beat48(50, 0); beat48(4, 1);
        total++;
        if (ovld48 !== 1'b1 || mask48 !== 48'h10) begin
            bad++; $display("FAIL oor48_mask valid=%b got=%h exp=10", ovld48, mask48);
        end
        total++;
        if (oor48 !== 1'b1 || dup48 !== 1'b0) begin
            bad++; $display("FAIL oor48_flags oor=%b dup=%b exp 1/0", oor48, dup48);
        end
`ifdef BIT_INDEX_PACKER_CNT_EN
        total++;
        if (cnt48 !== 6'd1) begin bad++; $display("FAIL oor48_cnt got=%0d exp=1", cnt48); end
`endif
        ordy48 = 1'b1;
        @(posedge clk); #1;
        ordy48 = 1'b0;
        total++;
        if (oor48 !== 1'b0 || irdy48 !== 1'b1) begin
            bad++; $display("FAIL oor48_clear oor=%b rdy=%b exp 0/1", oor48, irdy48);
        end
    endtask

    initial begin
        in_valid = 1'b0; in_idx = '0; in_null = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        v48 = 1'b0; idx48 = '0; null48 = 1'b0; last48 = 1'b0; ordy48 = 1'b0;
        test_reset();
        test_back_to_back();
        test_null_frame();
        test_dup();
        test_hold();
        test_mid_reset();
        test_oor48();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
